// File: rtl/alu_ctrl_muldiv.sv
// RV32IM execute-stage ALU control decoder plus an iterative multiply/divide engine
// (shift-add multiplier, restoring divider) with a valid/stall/done handshake.
module alu_ctrl_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            flush,
  input  logic            op5,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [1:0]      ALUop,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [3:0]      ALUcontrol,
  output logic            md_sel,
  output logic            md_stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4,
                         SLT = 4'd5, SLTU = 4'd6, SLL = 4'd7, SRL = 4'd8, SRA = 4'd9;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mcand, quo, dvsr, a_raw, res_q;
  logic [XLEN:0]     rem;
  logic              a_neg_q, b_neg_q, dz, ovf;

  // ---------------- decoder ----------------
  always_comb begin
    md_sel     = (ALUop == 2'b10) & op5 & (funct7 == 7'b0000001);
    ALUcontrol = ADD;
    case (ALUop)
      2'b01: ALUcontrol = SUB;
      2'b10: if (!md_sel) begin
        case (funct3)
          3'b000:  ALUcontrol = (op5 & funct7[5]) ? SUB : ADD;
          3'b001:  ALUcontrol = SLL;
          3'b010:  ALUcontrol = SLT;
          3'b011:  ALUcontrol = SLTU;
          3'b100:  ALUcontrol = XOR;
          3'b101:  ALUcontrol = funct7[5] ? SRA : SRL;
          3'b110:  ALUcontrol = OR;
          default: ALUcontrol = AND;
        endcase
      end
      default: ALUcontrol = ADD;
    endcase
  end

  // ---------------- operand preparation ----------------
  logic            accept, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;

  assign accept = in_valid & md_sel & (state == IDLE) & ~flush;

  // MUL low half is sign-agnostic, so it runs unsigned
  always_comb begin
    if (funct3[2]) begin
      a_sgn = ~funct3[0];
      b_sgn = ~funct3[0];
    end else begin
      a_sgn = (funct3[1:0] == 2'b01) | (funct3[1:0] == 2'b10);
      b_sgn = (funct3[1:0] == 2'b01);
    end
    a_neg = a_sgn & src_a[XLEN-1];
    b_neg = b_sgn & src_b[XLEN-1];
    mag_a = a_neg ? -src_a : src_a;
    mag_b = b_neg ? -src_b : src_b;
  end

  // ---------------- iteration step ----------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_nx;
  logic [XLEN+1:0]   r_sh, diff;
  logic              q_bit;

  always_comb begin
    mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nx = {mul_sum, prod[XLEN-1:1]};
    r_sh    = {rem, quo[XLEN-1]};
    diff    = r_sh - {2'b00, dvsr};
    q_bit   = ~diff[XLEN+1];
  end

  // ---------------- sign fix and special cases ----------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   q_fix, r_fix, result;

  always_comb begin
    prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
    q_fix    = (a_neg_q ^ b_neg_q) ? -quo : quo;
    r_fix    = a_neg_q ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    case (op)
      3'b000:         result = prod_fix[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101: result = dz ? '1 : (ovf ? MIN : q_fix);
      default:        result = dz ? a_raw : (ovf ? '0 : r_fix);
    endcase
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = BUSY;
      BUSY:    if (cnt == '0) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  assign md_done   = (state == DONE) & ~flush;
  assign md_stall  = accept | (state == BUSY);
  assign md_result = md_done ? result : res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= '0;
      prod    <= '0;
      mcand   <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      a_raw   <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      dz      <= 1'b0;
      ovf     <= 1'b0;
      res_q   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt     <= CW'(XLEN-1);
        op      <= funct3;
        prod    <= {{XLEN{1'b0}}, mag_b};
        mcand   <= mag_a;
        rem     <= '0;
        quo     <= mag_a;
        dvsr    <= mag_b;
        a_raw   <= src_a;
        a_neg_q <= a_neg;
        b_neg_q <= b_neg;
        dz      <= (src_b == '0);
        ovf     <= funct3[2] & ~funct3[0] & (src_a == MIN) & (src_b == '1);
      end else if (state == BUSY) begin
        cnt <= cnt - 1'b1;
        if (op[2]) begin
          rem <= q_bit ? diff[XLEN:0] : r_sh[XLEN:0];
          quo <= {quo[XLEN-2:0], q_bit};
        end else begin
          prod <= prod_nx;
        end
      end else if (md_done) begin
        res_q <= result;
      end
    end
  end
endmodule

// File: doc/alu_ctrl_muldiv.md
# alu_ctrl_muldiv

Parametrised ALU control unit with an attached iterative multiply/divide engine for the RV32IM execute stage. It decodes `ALUop`/`funct3`/`funct7`/`op5` into a 4-bit ALU operation for the full RV32I integer set. It also detects M-extension instructions and runs them on a multi-cycle shift-add multiplier / restoring divider. While an M operation is in flight it stalls the pipeline through a valid/stall/done handshake.

## Interface
- `XLEN`, 32: operand and result width; must be ≥ 8 and a power of two.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: the execute stage holds a valid instruction.
- `flush` input 1: pipeline flush; aborts any M operation.
- `op5` input 1: opcode bit 5 (1 = R-type, 0 = I-type).
- `funct7` input 7: instruction `funct7` field (immediate bits 31:25 for I-type).
- `funct3` input 3: instruction `funct3` field.
- `ALUop` input 2: main-decoder class (00 add, 01 sub/branch, 10 funct decode, 11 reserved).
- `src_a` input XLEN: rs1 operand.
- `src_b` input XLEN: rs2 operand.
- `ALUcontrol` output 4: ALU operation code (combinational).
- `md_sel` output 1: the current instruction is an M-extension op (combinational).
- `md_stall` output 1: freeze PC, IF/ID and ID/EX.
- `md_done` output 1: one-cycle pulse; `md_result` is valid.
- `md_result` output XLEN: multiply/divide result, held until the next accept.

## Operation
- ALUcontrol encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA.
  - Codes 000/001/010/011/101 keep their legacy meaning.
- Decode rules:
  - `ALUop` 00 gives ADD; 01 gives SUB; 11 gives ADD.
  - `ALUop` 10, by `funct3`:
    - 000: SUB if `op5 & funct7[5]`, else ADD.
    - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
    - 101: SRA if `funct7[5]`, else SRL.
    - 110: OR. 111: AND.
- `md_sel = (ALUop==10) & op5 & (funct7==7'b0000001)`. When `md_sel` is 1, `ALUcontrol` = ADD (don't-care).
- M ops by `funct3`:
  - 000 MUL (low XLEN).
  - 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high).
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Accept: `in_valid & md_sel & state==IDLE & ~flush`.
  - Latch `src_a`, `src_b` and `funct3`.
  - Signed operands are converted to magnitudes; the result sign is recorded.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY on accept. The counter loads XLEN−1.
  - BUSY:
    - Multiply: one shift-add step per cycle into a 2·XLEN product register.
    - Divide: one restoring-subtract step per cycle.
    - Counter decrements each cycle; at 0, go to DONE.
  - DONE: apply sign correction, assert `md_done`, go to IDLE.
  - `flush` in any state: go to IDLE next edge, no `md_done`, `md_result` unchanged.
- Special cases (fixed latency retained; result substituted in DONE):
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → dividend.
  - Signed overflow (min / −1): DIV → min; REM → 0.
- Arithmetic widths:
  - Product register is 2·XLEN bits.
  - Divider remainder register is XLEN+1 bits.
  - Sign fix is a two's-complement negate at full width.

## Timing
- Reset values: FSM IDLE, counter 0, `md_stall` 0, `md_done` 0, `md_result` 0.
- `ALUcontrol` and `md_sel` are purely combinational and not affected by reset.
- `md_stall`:
  - 1 in IDLE when `in_valid & md_sel & ~flush` (the accept cycle).
  - 1 throughout BUSY.
  - 0 in DONE, so the instruction retires on the `md_done` cycle.
- Latency: accept at cycle 0, BUSY in cycles 1..XLEN, `md_done` in cycle XLEN+1. Latency is fixed for all ops and operands.
- Back-to-back M ops: the next M instruction is presented in the cycle after DONE, with the FSM in IDLE, and is accepted there. There is no bubble beyond the fixed latency.
- The same instruction is never re-accepted: it leaves ID/EX on the DONE cycle.
- `flush` and accept in the same cycle: flush wins, no accept.
- `rst_n` low mid-operation: immediate return to reset values; `md_done` is never asserted for the aborted op.

## Test plan
- Decoder sweep, all `ALUop`/`funct3`/`op5`/`funct7[5]` combinations:
  - R-type SUB (`op5`=1, `funct7`=0x20, `funct3`=000) → 0001.
  - I-type ADDI with imm bit 30 set → 0000.
  - SRAI → 1001.
  - `funct7`=0x01 → `md_sel`=1.
- MUL, XLEN=32: 7 × 0xFFFFFFFD (−3) → `md_stall` high for cycles 0..32; `md_done` at cycle 33; `md_result` = 0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH of the same operands → 0x00000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Divide corner cases:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same → 0.
  - DIVU 100 / 0 → 0xFFFFFFFF.
  - REMU 100 / 0 → 100.
  - DIV −7 / 2 → 0xFFFFFFFD.
  - REM −7 / 2 → 0xFFFFFFFF.
- Abort paths:
  - `flush` asserted at BUSY cycle 10 → IDLE next edge, `md_stall` 0, no `md_done`, `md_result` unchanged.
  - `rst_n` pulsed low mid-BUSY → all outputs at reset values asynchronously.
- Back-to-back: MUL then DIVU presented consecutively → two `md_done` pulses exactly 34 cycles apart, both results correct.
